cpu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the accumulator machine. It owns the PC, IR and AC, and sequences the shared main memory (synchronous, 1-cycle read latency) and the combinational ALU. It sits at the top of the computer between `MainMemory` and `ALU`, and drives every address, write strobe and ALU opcode.

---
 rtl/cpu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_cpu_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller for the accumulator machine.
// Owns PC, IR and AC. Drives the shared main memory (1-cycle read latency) and the
// combinational ALU.
// Build macro CPU_SEQ_DIVZERO_TRAP_EN: when defined, a divide by zero leaves AC untouched
// and halts the machine. When undefined, AC is forced to 16'hFFFF and execution continues.
// The sticky fault flag is set in both builds.
module cpu_sequencer #(
  parameter int unsigned       ADDR_W   = 14,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  input  logic [15:0]       mem_rdata,
  output logic [3:0]        alu_opcode,
  output logic [15:0]       alu_a,
  output logic [15:0]       alu_b,
  input  logic [15:0]       alu_result,
  output logic              halted,
  output logic              fault,
  output logic [ADDR_W-1:0] pc_out,
  output logic [15:0]       ac_out
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLatch,
    StDecode,
    StOperand,
    StHalted
  } state_e;

  // Non-ALU instruction opcodes, IR[14:12] when IR[15] = 0
  localparam logic [2:0] OpHalt  = 3'b000;
  localparam logic [2:0] OpLoad  = 3'b001;
  localparam logic [2:0] OpStore = 3'b010;
  localparam logic [2:0] OpJmp   = 3'b011;
  localparam logic [2:0] OpJz    = 3'b100;
  localparam logic [2:0] OpLoadi = 3'b101;

  localparam logic [3:0] AluDiv  = 4'b0011;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [15:0]       ir_q;
  logic [15:0]       ac_q;
  logic              fault_q;

  logic              is_alu;
  logic [2:0]        op;
  logic [ADDR_W-1:0] alu_addr;
  logic [ADDR_W-1:0] op_addr;
  logic              div_zero;

  assign is_alu   = ir_q[15];
  assign op       = ir_q[14:12];
  // ALU ops carry an 11-bit address, all others a 12-bit one; both zero-extend
  assign alu_addr = ADDR_W'(ir_q[10:0]);
  assign op_addr  = ADDR_W'(ir_q[11:0]);
  // Only meaningful in OPERAND, where mem_rdata holds the operand word
  assign div_zero = is_alu && (ir_q[14:11] == AluDiv) && (mem_rdata == 16'h0000);

  // Sequencer FSM together with the architectural registers it owns
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      ac_q    <= 16'h0000;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run) state_q <= StFetch;
        end

        StFetch: begin
          state_q <= StLatch;
        end

        // Read data for the FETCH address is valid now
        StLatch: begin
          ir_q    <= mem_rdata;
          pc_q    <= pc_q + ADDR_W'(1);
          state_q <= StDecode;
        end

        StDecode: begin
          state_q <= StFetch;
          if (is_alu) begin
            state_q <= StOperand;
          end else begin
            case (op)
              OpHalt:  state_q <= StHalted;
              OpLoad:  state_q <= StOperand;
              OpJmp:   pc_q <= op_addr;
              OpJz: begin
                if (ac_q == 16'h0000) pc_q <= op_addr;
              end
              OpLoadi: ac_q <= 16'(ir_q[11:0]);
              // STORE only drives the bus this cycle; NOP does nothing
              default: ;
            endcase
          end
        end

        // Operand word requested in DECODE is on mem_rdata now
        StOperand: begin
          state_q <= StFetch;
          if (!is_alu) begin
            ac_q <= mem_rdata;
          end else if (div_zero) begin
            fault_q <= 1'b1;
`ifdef CPU_SEQ_DIVZERO_TRAP_EN
            state_q <= StHalted;
`else
            ac_q    <= 16'hFFFF;
`endif
          end else begin
            ac_q <= alu_result;
          end
        end

        // Only reset leaves HALTED
        StHalted: begin
          state_q <= StHalted;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Moore bus decode; reset forces IDLE so every strobe drops immediately
  always_comb begin
    mem_addr   = 16'h0000;
    mem_wdata  = 16'h0000;
    mem_we     = 1'b0;
    alu_opcode = 4'b0000;
    unique case (state_q)
      StFetch: begin
        mem_addr = 16'(pc_q);
      end
      StDecode: begin
        if (is_alu) begin
          mem_addr = 16'(alu_addr);
        end else if (op == OpLoad) begin
          mem_addr = 16'(op_addr);
        end else if (op == OpStore) begin
          mem_addr  = 16'(op_addr);
          mem_wdata = ac_q;
          mem_we    = 1'b1;
        end
      end
      StOperand: begin
        alu_opcode = ir_q[14:11];
      end
      default: ;
    endcase
  end

  assign alu_a  = ac_q;
  // Operand goes straight from memory to the ALU; the only input-to-output path
  assign alu_b  = mem_rdata;
  assign halted = (state_q == StHalted);
  assign fault  = fault_q;
  assign pc_out = pc_q;
  assign ac_out = ac_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench. An instruction-level reference model turns each
// program into the expected per-cycle bus trace plus final PC/AC/fault; a monitor pops and
// compares one trace entry per cycle while the machine runs.
module tb_cpu_sequencer;
  localparam int unsigned       ADDR_W    = 14;
  localparam logic [ADDR_W-1:0] RESET_PC  = 14'h3FFF;
  localparam int                MAX_INSTR = 60;
  localparam int                N_RANDOM  = 20;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              run = 1'b0;
  logic [15:0]       mem_addr, mem_wdata, mem_rdata, alu_a, alu_b, alu_result, ac_out;
  logic              mem_we, halted, fault;
  logic [3:0]        alu_opcode;
  logic [ADDR_W-1:0] pc_out;

  cpu_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .halted(halted), .fault(fault), .pc_out(pc_out), .ac_out(ac_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [3:0]  op;
    logic        hlt;
  } bus_t;

  logic [15:0]       mem     [0:16383];
  logic [15:0]       ref_mem [0:16383];
  bus_t              exp_q[$];
  logic [ADDR_W-1:0] exp_pc;
  logic [15:0]       exp_ac;
  logic              exp_fault;
  logic              active = 1'b0;
  int                n_cmp = 0;
  int                n_bad = 0;
  int                cyc_no = 0;

  // Bench-side ALU; opcode 3 is divide
  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return 16'(a * b);
      4'd3:    return (b == 16'h0) ? 16'h0 : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return ~a;
      4'd8:    return b;
      4'd9:    return a << b[3:0];
      4'd10:   return a >> b[3:0];
      default: return a + b + {12'h0, op};
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_a, alu_b);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic we, input logic [15:0] wd,
                      input logic [3:0] op, input logic h);
    bus_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.op = op; e.hlt = h;
    exp_q.push_back(e);
  endtask

  // Synchronous single-port memory; no read data on a write cycle
  task automatic mem_proc();
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr[13:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[13:0]];
    end
  endtask

  task automatic monitor();
    bus_t e, g;
    forever begin
      @(negedge clk);
      if (active && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g.addr = mem_addr; g.we = mem_we; g.wdata = mem_we ? mem_wdata : 16'h0;
        g.op = alu_opcode; g.hlt = halted;
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL bus cycle %0d: got addr=%h we=%b wdata=%h op=%h halted=%b, expected addr=%h we=%b wdata=%h op=%h halted=%b",
                   cyc_no, g.addr, g.we, g.wdata, g.op, g.hlt,
                   e.addr, e.we, e.wdata, e.op, e.hlt);
        end
        check("alu_b_passthrough", {16'h0, alu_b}, {16'h0, mem_rdata});
        cyc_no++;
      end
    end
  endtask

  // Instruction-level interpreter producing the expected cycle trace
  task automatic model_program();
    logic [ADDR_W-1:0] pc, a;
    logic [15:0]       ac, ir, b;
    logic              flt, stop;
    pc = RESET_PC; ac = 16'h0; flt = 1'b0; stop = 1'b0;
    for (int n = 0; n < MAX_INSTR && !stop; n++) begin
      push(16'(pc), 1'b0, 16'h0, 4'h0, 1'b0);
      ir = ref_mem[pc];
      pc = pc + 14'd1;
      push(16'h0, 1'b0, 16'h0, 4'h0, 1'b0);
      if (ir[15]) begin
        a = {3'b0, ir[10:0]};
        b = ref_mem[a];
        push(16'(a), 1'b0, 16'h0, 4'h0, 1'b0);
        push(16'h0, 1'b0, 16'h0, ir[14:11], 1'b0);
        if (ir[14:11] == 4'd3 && b == 16'h0) begin
          flt = 1'b1;
`ifdef CPU_SEQ_DIVZERO_TRAP_EN
          stop = 1'b1;
`else
          ac = 16'hFFFF;
`endif
        end else begin
          ac = alu_f(ir[14:11], ac, b);
        end
      end else begin
        a = {2'b0, ir[11:0]};
        case (ir[14:12])
          3'd0: begin push(16'h0, 1'b0, 16'h0, 4'h0, 1'b0); stop = 1'b1; end
          3'd1: begin
            push(16'(a), 1'b0, 16'h0, 4'h0, 1'b0);
            push(16'h0, 1'b0, 16'h0, ir[14:11], 1'b0);
            ac = ref_mem[a];
          end
          3'd2: begin push(16'(a), 1'b1, ac, 4'h0, 1'b0); ref_mem[a] = ac; end
          3'd3: begin push(16'h0, 1'b0, 16'h0, 4'h0, 1'b0); pc = a; end
          3'd4: begin push(16'h0, 1'b0, 16'h0, 4'h0, 1'b0); if (ac == 16'h0) pc = a; end
          3'd5: begin push(16'h0, 1'b0, 16'h0, 4'h0, 1'b0); ac = {4'h0, ir[11:0]}; end
          default: push(16'h0, 1'b0, 16'h0, 4'h0, 1'b0);
        endcase
      end
    end
    if (stop) repeat (3) push(16'h0, 1'b0, 16'h0, 4'h0, 1'b1);
    exp_pc = pc; exp_ac = ac; exp_fault = flt;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0;
  endtask

  function automatic logic [15:0] rand_instr();
    int          k;
    logic [11:0] da, ja;
    k  = $urandom_range(0, 99);
    da = 12'($urandom_range(64, 95));
    if ($urandom_range(0, 7) == 0) da = 12'($urandom);
    ja = 12'($urandom_range(0, 63));
    if (k < 30)      return {1'b1, 4'($urandom), da[10:0]};
    else if (k < 45) return {4'b0001, da};
    else if (k < 58) return {4'b0010, da};
    else if (k < 66) return {4'b0011, ja};
    else if (k < 76) return {4'b0100, ja};
    else if (k < 90) return {4'b0101, 12'($urandom)};
    else if (k < 97) return {1'b0, 3'($urandom_range(6, 7)), 12'($urandom)};
    else             return {4'b0000, 12'($urandom)};
  endfunction

  task automatic build_random();
    clear_ref();
    for (int i = 0; i < 64; i++) ref_mem[i] = rand_instr();
    ref_mem[RESET_PC] = rand_instr();
    for (int i = 64; i < 96; i++)
      ref_mem[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
  endtask

  // Assert reset (possibly mid-instruction), load memory from ref_mem, release
  task automatic apply_reset();
    active = 1'b0;
    run = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    check("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
    check("rst_alu_opcode", {28'h0, alu_opcode}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_pc", {18'h0, pc_out}, {18'h0, RESET_PC});
    check("rst_ac", {16'h0, ac_out}, 32'h0);
    for (int i = 0; i < 16384; i++) mem[i] <= ref_mem[i];
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic start_run(input bit hold, input bit use_sb);
    @(posedge clk); #1;
    run = 1'b1;
    @(posedge clk); #1;
    if (!hold) run = 1'b0;
    cyc_no = 0;
    active = use_sb;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d trace entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
    active = 1'b0;
    check("final_pc", {18'h0, pc_out}, {18'h0, exp_pc});
    check("final_ac", {16'h0, ac_out}, {16'h0, exp_ac});
    check("final_fault", {31'h0, fault}, {31'h0, exp_fault});
    run = 1'b0;
  endtask

  task automatic run_program(input bit hold);
    apply_reset();
    model_program();
    start_run(hold, 1'b1);
    wait_drain();
  endtask

  task automatic stimulus();
    // Reset then idle with run low
    clear_ref();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_mem_we", {31'h0, mem_we}, 32'h0);
      check("idle_mem_addr", {16'h0, mem_addr}, 32'h0);
      check("idle_pc", {18'h0, pc_out}, {18'h0, RESET_PC});
      check("idle_ac", {16'h0, ac_out}, 32'h0);
      check("idle_halted", {31'h0, halted}, 32'h0);
    end

    // LOAD / ADD / STORE / HALT, entered through a NOP at the wrapping reset PC
    clear_ref();
    ref_mem[RESET_PC] = 16'h6000;
    ref_mem[0] = 16'h1010; ref_mem[1] = 16'h8011; ref_mem[2] = 16'h2012; ref_mem[3] = 16'h0000;
    ref_mem[16'h10] = 16'd5; ref_mem[16'h11] = 16'd7;
    run_program(1'b1);
    check("store_result", {16'h0, mem[14'h12]}, 32'd12);

    // JZ taken, then JZ not taken
    clear_ref();
    ref_mem[RESET_PC] = 16'h6000;
    ref_mem[0] = 16'h5000; ref_mem[1] = 16'h4020;
    ref_mem[16'h20] = 16'h5001; ref_mem[16'h21] = 16'h4030; ref_mem[16'h22] = 16'h0000;
    run_program(1'b0);

    // Divide by zero
    clear_ref();
    ref_mem[RESET_PC] = 16'h6000;
    ref_mem[0] = 16'h5009; ref_mem[1] = 16'h9850; ref_mem[2] = 16'h0000;
    run_program(1'b1);
    check("divzero_fault", {31'h0, fault}, 32'h1);

    // Reset during the DECODE cycle of a STORE
    clear_ref();
    ref_mem[RESET_PC] = 16'h505A;
    ref_mem[0] = 16'h2030; ref_mem[1] = 16'h0000;
    ref_mem[16'h30] = 16'hBEEF;
    apply_reset();
    start_run(1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("store_we", {31'h0, mem_we}, 32'h1);
    check("store_addr", {16'h0, mem_addr}, 32'h30);
    check("store_wdata", {16'h0, mem_wdata}, 32'h5A);
    #2;
    reset_n = 1'b0;
    run = 1'b0;
    #1;
    check("abort_we", {31'h0, mem_we}, 32'h0);
    check("abort_pc", {18'h0, pc_out}, {18'h0, RESET_PC});
    check("abort_ac", {16'h0, ac_out}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_target", {16'h0, mem[14'h30]}, 32'hBEEF);

    // Random programs
    for (int t = 0; t < N_RANDOM; t++) begin
      build_random();
      run_program(1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    fork
      mem_proc();
      monitor();
      stimulus();
      begin
        #1_000_000;
        n_cmp++; n_bad++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
